exe_div_unit: RTL and testbench

//  Multi-cycle 32-bit integer divider in the EXE stage, executing OP_DIV / OP_DIVU.

---
 rtl/exe_div_unit.sv | 145 ++++++++++++++
 tb/tb_exe_div_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_div_unit.sv
// Multi-cycle radix-2 restoring divider for OP_DIV / OP_DIVU in EXE; quotient to LO, remainder to HI.
// Optional macro DIV_FASTZERO_EN: a zero divisor completes straight from IDLE.
module exe_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Div_Start,
  input  logic             Div_Signed,
  input  logic [WIDTH-1:0] Div_A,
  input  logic [WIDTH-1:0] Div_B,
  input  logic             Div_Ack,
  input  logic             Div_Flush,
  output logic             Div_Stall,
  output logic             Div_Done,
  output logic [WIDTH-1:0] Div_Quot,
  output logic [WIDTH-1:0] Div_Rem
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;

  logic [WIDTH-1:0]  dvd;
  logic [WIDTH-1:0]  dvs;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  a_raw;
  logic              q_neg;
  logic              r_neg;
  logic              b_zero;

  logic [WIDTH:0]          rem_shift;
  logic signed [WIDTH+1:0] trial;
  logic                    q_bit;
  logic [WIDTH-1:0]        rem_step;
  logic                    launch;
  logic                    b_is_zero;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn_mode);
    return (sgn_mode && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign Div_Stall = Div_Start & ~Div_Done;
  assign launch    = (state == S_IDLE) && Div_Start && !Div_Flush;
  assign b_is_zero = (Div_B == '0);

  // Restoring step: the two extra trial bits keep the sign test exact even when the shifted remainder uses bit WIDTH.
  always_comb begin
    rem_shift = {rem, dvd[WIDTH-1]};
    trial     = $signed({1'b0, rem_shift}) - $signed({2'b00, dvs});
    q_bit     = (trial >= 0);
    rem_step  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    if (Div_Flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (Div_Start) begin
`ifdef DIV_FASTZERO_EN
            state_nxt = b_is_zero ? S_DONE : S_CALC;
`else
            state_nxt = S_CALC;
`endif
          end
        end
        S_CALC:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  if (Div_Ack) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Control and architectural outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      Div_Done <= 1'b0;
      Div_Quot <= '0;
      Div_Rem  <= '0;
    end else begin
      state <= state_nxt;
      if (Div_Flush) begin
        Div_Done <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (Div_Start) begin
              cnt <= '0;
`ifdef DIV_FASTZERO_EN
              if (b_is_zero) begin
                Div_Quot <= '1;
                Div_Rem  <= Div_A;
                Div_Done <= 1'b1;
              end
`endif
            end
          end
          S_CALC: cnt <= cnt + 1'b1;
          S_FIX: begin
            Div_Quot <= b_zero ? '1 : cond_neg(dvd, q_neg);
            Div_Rem  <= b_zero ? a_raw : cond_neg(rem, r_neg);
            Div_Done <= 1'b1;
          end
          S_DONE:  if (Div_Ack) Div_Done <= 1'b0;
          default: Div_Done <= 1'b0;
        endcase
      end
    end
  end

  // Datapath: dividend register doubles as the quotient shift register
  always_ff @(posedge clk) begin
    if (launch) begin
      dvd    <= abs_val(Div_A, Div_Signed);
      dvs    <= abs_val(Div_B, Div_Signed);
      rem    <= '0;
      a_raw  <= Div_A;
      b_zero <= b_is_zero;
      q_neg  <= Div_Signed & (Div_A[WIDTH-1] ^ Div_B[WIDTH-1]);
      r_neg  <= Div_Signed & Div_A[WIDTH-1];
    end else if (state == S_CALC) begin
      dvd <= {dvd[WIDTH-2:0], q_bit};
      rem <= rem_step;
    end
  end

endmodule

// File: tb/tb_exe_div_unit.sv
// Self-checking bench for exe_div_unit: scoreboard of expected quotient/remainder per launched divide.
`timescale 1ns/1ps
module tb_exe_div_unit;

  localparam int FULL_LAT = 34;
`ifdef DIV_FASTZERO_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Div_Start, Div_Signed, Div_Ack, Div_Flush;
  logic [31:0] Div_A, Div_B;
  logic        Div_Stall, Div_Done;
  logic [31:0] Div_Quot, Div_Rem;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  exe_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .Div_Start(Div_Start), .Div_Signed(Div_Signed),
    .Div_A(Div_A), .Div_B(Div_B),
    .Div_Ack(Div_Ack), .Div_Flush(Div_Flush),
    .Div_Stall(Div_Stall), .Div_Done(Div_Done),
    .Div_Quot(Div_Quot), .Div_Rem(Div_Rem)
  );

  always #5 clk = ~clk;

  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (sgn) begin
      q = sa / sbv;
      r = sa % sbv;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Launch one divide, follow it to Done, hold Ack low for 'hold' cycles, then Ack with Start still high.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                         input int hold);
    exp_t e;
    int   lat, stall_err, exp_lat;
    e.q = eq;
    e.r = er;
    sb.push_back(e);
    exp_lat = (b == 32'h0) ? ZERO_LAT : FULL_LAT;
    @(posedge clk); #1;
    Div_Start = 1'b1; Div_Signed = sgn; Div_A = a; Div_B = b; Div_Ack = 1'b0;
    #1;
    lat = -1;
    stall_err = 0;
    for (int i = 0; i < 60; i++) begin
      if (Div_Done === 1'b1) begin
        lat = i;
        break;
      end
      if (Div_Stall !== 1'b1) stall_err++;
      @(posedge clk); #2;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (stall_err != 0) begin
      errors++;
      $display("FAIL %s stall: low in %0d busy cycles, expected 0", name, stall_err);
    end
    checks++;
    if (Div_Stall !== 1'b0) begin
      errors++;
      $display("FAIL %s stall_at_done: got %b, expected 0", name, Div_Stall);
    end
    e = sb.pop_front();
    checks++;
    if (Div_Quot !== e.q) begin
      errors++;
      $display("FAIL %s quot: got %h, expected %h", name, Div_Quot, e.q);
    end
    checks++;
    if (Div_Rem !== e.r) begin
      errors++;
      $display("FAIL %s rem: got %h, expected %h", name, Div_Rem, e.r);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      checks++;
      if (Div_Done !== 1'b1 || Div_Quot !== e.q || Div_Rem !== e.r) begin
        errors++;
        $display("FAIL %s hold%0d: got done=%b q=%h r=%h, expected done=1 q=%h r=%h",
                 name, h, Div_Done, Div_Quot, Div_Rem, e.q, e.r);
      end
    end
    Div_Ack = 1'b1;
    @(posedge clk); #1;
    Div_Ack = 1'b0;
    Div_Start = 1'b0;
    #1;
    checks++;
    if (Div_Done !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_drop: got done=%b, expected 0", name, Div_Done);
    end
    last_q = e.q;
    last_r = e.r;
  endtask

  task automatic test_reset();
    rst = 1'b0; Div_Start = 1'b0; Div_Signed = 1'b0; Div_A = '0; Div_B = '0;
    Div_Ack = 1'b0; Div_Flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (Div_Done !== 1'b0 || Div_Quot !== 32'h0 || Div_Rem !== 32'h0 || Div_Stall !== 1'b0) begin
      errors++;
      $display("FAIL reset: got done=%b q=%h r=%h stall=%b, expected all 0",
               Div_Done, Div_Quot, Div_Rem, Div_Stall);
    end
    #1;
    rst = 1'b1;
  endtask

  task automatic test_vectors();
    run_div("divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,        0);
    run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    run_div("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        0);
    run_div("div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        0);
    run_div("divu_ovf",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0);
    run_div("divu_zero",   1'b0, 32'h1234,      32'h0,         32'hFFFF_FFFF, 32'h1234,     0);
    run_div("div_zero_neg",1'b1, 32'h8000_0005, 32'h0,         32'hFFFF_FFFF, 32'h8000_0005, 0);
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    Div_Start = 1'b1; Div_Signed = 1'b0; Div_A = 32'd1000; Div_B = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
    end
    Div_Flush = 1'b1;
    @(posedge clk); #1;
    Div_Flush = 1'b0;
    Div_Start = 1'b0;
    #1;
    checks++;
    if (Div_Done !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: got %b, expected 0", Div_Done);
    end
    checks++;
    if (Div_Quot !== last_q || Div_Rem !== last_r) begin
      errors++;
      $display("FAIL flush_keep: got q=%h r=%h, expected q=%h r=%h", Div_Quot, Div_Rem, last_q, last_r);
    end
    run_div("flush_new_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
  endtask

  task automatic test_ack_hold();
    run_div("ack_hold", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      checks++;
      if (Div_Done !== 1'b0) begin
        errors++;
        $display("FAIL ack_no_relaunch%0d: got done=%b, expected 0", i, Div_Done);
      end
    end
  endtask

  task automatic test_ack_ignored();
    exp_t e;
    int   lat;
    e.q = 32'd14;
    e.r = 32'd2;
    sb.push_back(e);
    @(posedge clk); #1;
    Div_Start = 1'b1; Div_Signed = 1'b0; Div_A = 32'd100; Div_B = 32'd7;
    #1;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      if (Div_Done === 1'b1) begin
        lat = i;
        break;
      end
      Div_Ack = (i == 5);
      if (i == 8) Div_Start = 1'b0;
      @(posedge clk); #2;
    end
    e = sb.pop_front();
    checks++;
    if (lat != FULL_LAT) begin
      errors++;
      $display("FAIL ack_ignored latency: got %0d, expected %0d", lat, FULL_LAT);
    end
    checks++;
    if (Div_Quot !== e.q || Div_Rem !== e.r) begin
      errors++;
      $display("FAIL ack_ignored result: got q=%h r=%h, expected q=%h r=%h", Div_Quot, Div_Rem, e.q, e.r);
    end
    Div_Ack = 1'b1;
    @(posedge clk); #1;
    Div_Ack = 1'b0;
    last_q = e.q;
    last_r = e.r;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, q, r;
    logic        s;
    for (int n = 0; n < 8; n++) begin
      s = n[0];
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (n == 5) b = 32'hFFFF_FFFF;
      model(s, a, b, q, r);
      run_div($sformatf("rand%0d", n), s, a, b, q, r, 0);
    end
  endtask

  task automatic test_reset_mid();
    run_div("pre_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    @(posedge clk); #1;
    Div_Start = 1'b1; Div_Signed = 1'b0; Div_A = 32'd5000; Div_B = 32'd9;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    Div_Start = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (Div_Done !== 1'b0 || Div_Quot !== 32'h0 || Div_Rem !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got done=%b q=%h r=%h, expected all 0", Div_Done, Div_Quot, Div_Rem);
    end
    rst = 1'b1;
    run_div("post_rst", 1'b0, 32'd5000, 32'd9, 32'd555, 32'd5, 0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_flush();
    test_ack_hold();
    test_ack_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
